// File: rtl/dmem_pkg.sv
// Shared constants and store-buffer entry type for the buffered data memory.
package dmem_pkg;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned RAM_WORDS = 256;
  localparam int unsigned IDX_W     = 8;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// In-order store FIFO. Exposes its contents oldest-first so the owner can
// run a forwarding search without knowing the pointer layout.
module sb_fifo import dmem_pkg::*; #(
  parameter int unsigned Depth = DEPTH,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  sb_entry_t       push_entry_i,
  output logic            full_o,
  output logic            empty_o,
  output sb_entry_t       head_o,
  output sb_entry_t       entries_o [Depth],
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  sb_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Index 0 is the oldest entry; slots at or beyond count_o are stale.
  always_comb begin
    for (int i = 0; i < int'(Depth); i++) begin
      entries_o[i] = mem_q[PtrW'((int'(rd_ptr_q) + i) % int'(Depth))];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry_i;
      end
    end
  end

endmodule

// File: rtl/store_buffer_dmem.sv
// Data memory fronted by a store buffer: stores retire to RAM in idle cycles,
// loads own the RAM port and see pending stores through forwarding.
module store_buffer_dmem import dmem_pkg::*; #(
  parameter int unsigned DEPTH     = dmem_pkg::DEPTH,
  parameter int unsigned RAM_WORDS = dmem_pkg::RAM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        stall,
  output logic [2:0]  sb_count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]      ram_q [RAM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             push, pop, full, empty;
  sb_entry_t        push_entry, head;
  sb_entry_t        entries [DEPTH];
  logic [CntW-1:0]  count;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic             unused_adr;

  assign idx        = adr[IDX_W+1:2];
  assign unused_adr = ^{adr[31:IDX_W+2], adr[1:0]};

  // A load in the same cycle cancels the store outright rather than stalling it.
  assign stall      = mem_write & ~mem_read & full & ~rst;
  assign push       = mem_write & ~mem_read & ~full;
  assign pop        = ~mem_read & ~empty;
  assign push_entry = '{idx: idx, data: write_data};
  assign sb_count   = 3'(count);

  sb_fifo #(
    .Depth (DEPTH),
    .CntW  (CntW)
  ) u_sb_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i (push_entry),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (head),
    .entries_o    (entries),
    .count_o      (count)
  );

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!fwd_hit && (CntW'(i) < count) && (entries[i].idx == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[i].data;
      end
    end
  end

  assign read_data = mem_read ? (fwd_hit ? fwd_data : ram_q[idx]) : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst && pop) begin
      ram_q[head.idx] <= head.data;
    end
  end

endmodule

// File: tb/tb_store_buffer_dmem.sv
// Bench for store_buffer_dmem: a default-depth and a single-entry instance
// driven in lockstep and compared against a list-based memory model.
module tb_store_buffer_dmem;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, write_data;
  logic        mem_read, mem_write;
  logic [31:0] rd0, rd1;
  logic        st0, st1;
  logic [2:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  store_buffer_dmem #(.DEPTH(4), .RAM_WORDS(256)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .adr        (adr),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .read_data  (rd0),
    .stall      (st0),
    .sb_count   (cnt0)
  );

  store_buffer_dmem #(.DEPTH(1), .RAM_WORDS(256)) u_dut_shallow (
    .clk        (clk),
    .rst        (rst),
    .adr        (adr),
    .write_data (write_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .read_data  (rd1),
    .stall      (st1),
    .sb_count   (cnt1)
  );

  int errors = 0;
  int checks = 0;

  // Model: pending stores as an oldest-first list per instance, plus a RAM image.
  sb_entry_t   m_ent [2][4];
  int          m_size [2];
  int          m_depth [2];
  logic [31:0] m_ram [2][256];

  logic [31:0] obs_rd [2];
  logic        obs_stall [2];
  logic [2:0]  obs_cnt [2];
  logic        pred_stall1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input int k, input logic [7:0] idx);
    for (int i = m_size[k] - 1; i >= 0; i--) begin
      if (m_ent[k][i].idx == idx) return m_ent[k][i].data;
    end
    return m_ram[k][idx];
  endfunction

  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic r, input logic w, input logic rs);
    logic [7:0] idx;
    bit         drain, push, exp_stall;
    adr = a; write_data = wd; mem_read = r; mem_write = w; rst = rs;
    #1;
    idx = a[9:2];
    obs_rd[0] = rd0; obs_stall[0] = st0; obs_cnt[0] = cnt0;
    obs_rd[1] = rd1; obs_stall[1] = st1; obs_cnt[1] = cnt1;
    for (int k = 0; k < 2; k++) begin
      exp_stall = w && !r && !rs && (m_size[k] == m_depth[k]);
      chk($sformatf("%s.rd%0d", tag, k), obs_rd[k], r ? ref_load(k, idx) : 32'd0);
      chk($sformatf("%s.stall%0d", tag, k), 32'(obs_stall[k]), 32'(exp_stall));
      chk($sformatf("%s.cnt%0d", tag, k), 32'(obs_cnt[k]), 32'(m_size[k]));
    end
    pred_stall1 = w && !r && !rs && (m_size[1] == m_depth[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_size[k] = 0;
      end else begin
        drain = !r && (m_size[k] > 0);
        push  = w && !r && (m_size[k] < m_depth[k]);
        if (drain) begin
          m_ram[k][m_ent[k][0].idx] = m_ent[k][0].data;
          for (int i = 0; i < 3; i++) m_ent[k][i] = m_ent[k][i+1];
          m_size[k]--;
        end
        if (push) begin
          m_ent[k][m_size[k]].idx  = idx;
          m_ent[k][m_size[k]].data = wd;
          m_size[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] d, a;
    logic        r, w, rs;
    m_depth[0] = 4; m_depth[1] = 1;
    m_size[0]  = 0; m_size[1]  = 0;
    rst = 1'b1; adr = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Give every RAM word a known value; re-present any store the shallow DUT refuses.
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      step("init", 32'(i) << 2, d, 1'b0, 1'b1, 1'b0);
      if (pred_stall1) step("init_retry", 32'(i) << 2, d, 1'b0, 1'b1, 1'b0);
    end
    idle(2);

    step("fwd_st", 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    step("fwd_ld", 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fwd_value", obs_rd[0], 32'hDEADBEEF);
    chk("fwd_count", 32'(obs_cnt[0]), 32'd1);
    idle(2);

    step("nw_st1", 32'h20, 32'h1, 1'b0, 1'b1, 1'b0);
    step("nw_ld1", 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    step("nw_st2", 32'h20, 32'h2, 1'b0, 1'b1, 1'b0);
    step("nw_ld2", 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("newest_wins", obs_rd[0], 32'h2);
    idle(2);
    step("nw_ram", 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("newest_ram", obs_rd[0], 32'h2);

    step("fill_st", 32'h30, 32'hA5A5_0030, 1'b0, 1'b1, 1'b0);
    step("fill_stall", 32'h34, 32'hA5A5_0034, 1'b0, 1'b1, 1'b0);
    chk("full_stall", 32'(obs_stall[1]), 32'd1);
    chk("full_count", 32'(obs_cnt[1]), 32'd1);
    step("fill_retry", 32'h34, 32'hA5A5_0034, 1'b0, 1'b1, 1'b0);
    chk("retry_accept", 32'(obs_stall[1]), 32'd0);
    step("fill_ld", 32'h34, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("retry_value", obs_rd[1], 32'hA5A5_0034);

    step("pd_st1", 32'h40, 32'h4040_4040, 1'b0, 1'b1, 1'b0);
    step("pd_st2", 32'h44, 32'h4444_4444, 1'b0, 1'b1, 1'b0);
    chk("push_drain_cnt", 32'(obs_cnt[0]), 32'd1);
    step("pd_ld", 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);

    step("rs_st", 32'h0, 32'hBAD0_0000, 1'b0, 1'b1, 1'b0);
    step("rs_ld", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0);
    step("rs_pulse", 32'h8, 32'hBAD0_0008, 1'b0, 1'b1, 1'b1);
    step("rs_ld0", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("reset_count", 32'(obs_cnt[0]), 32'd0);
    step("rs_ld8", 32'h8, 32'h0, 1'b1, 1'b0, 1'b0);

    step("alias_st", 32'h403, 32'hC0DE_0403, 1'b0, 1'b1, 1'b0);
    step("alias_ld", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("alias_value", obs_rd[0], 32'hC0DE_0403);
    step("rw_both", 32'h8, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    chk("rw_no_stall", 32'(obs_stall[0]), 32'd0);
    step("rw_after", 32'h8, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rw_count", 32'(obs_cnt[0]), 32'd1);

    for (int i = 0; i < 400; i++) begin
      a  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | 32'h400;
      r  = ($urandom_range(0, 9) < 4);
      w  = ($urandom_range(0, 9) < 5);
      rs = ($urandom_range(0, 49) == 0);
      step("rand", a, $urandom, r, w, rs);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
